watch_set_controller: RTL and testbench

WATCH_SET_CONTROLLER -- requirements
Module: watch_set_controller

---
 rtl/watch_set_controller.sv | 211 +++++++++++++++++++++
 tb/tb_watch_set_controller.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_set_controller.sv
// -----------------------------------------------------------------------------
// watch_set_controller
//
// Time-setting front end for a digital watch. In RUN it divides CLK down to a
// one-cycle 1 Hz count enable (TICK) for the external watch counter. A MODE
// button press copies the live time into edit registers and steps through
// hours, minutes and seconds. INC presses bump the selected field. Leaving the
// seconds field writes the edited time back with a one-cycle LOAD strobe.
//
// Parameters
//   TICK_DIV    CLK cycles per 1 Hz tick (2 .. 2**26)
//
// Ports
//   CLK         single clock, rising edge
//   RST_N       asynchronous active-low reset
//   BTN_MODE    asynchronous mode button, active-high level
//   BTN_INC     asynchronous increment button, active-high level
//   CUR_HRS/MIN/SEC   live time from the watch counter
//   TICK        one-cycle count enable to the watch counter
//   LOAD        one-cycle load strobe to the watch counter
//   LOAD_HRS/MIN/SEC  value to load (mirrors the edit registers)
//   DISP_HRS/MIN/SEC  time to display (live in RUN, edit value while setting)
//   EDIT_FIELD  0 none, 1 hours, 2 minutes, 3 seconds
// -----------------------------------------------------------------------------
module watch_set_controller #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_MODE,
  input  logic       BTN_INC,
  input  logic [5:0] CUR_SEC,
  input  logic [5:0] CUR_MIN,
  input  logic [4:0] CUR_HRS,
  output logic       TICK,
  output logic       LOAD,
  output logic [5:0] LOAD_SEC,
  output logic [5:0] LOAD_MIN,
  output logic [4:0] LOAD_HRS,
  output logic [5:0] DISP_SEC,
  output logic [5:0] DISP_MIN,
  output logic [4:0] DISP_HRS,
  output logic [1:0] EDIT_FIELD
);

  localparam int unsigned      CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // State encoding doubles as the EDIT_FIELD code.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HRS = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       mode_sync;
  logic [1:0]       inc_sync;
  logic             mode_prev;
  logic             inc_prev;
  logic [2:0]       sample_valid;
  logic             mode_evt;
  logic             inc_evt;

  logic [CNT_W-1:0] presc;
  logic             load_q;
  logic             load_nxt;
  logic             capture;
  logic             inc_hrs;
  logic             inc_min;
  logic             inc_sec;

  logic [4:0]       edit_hrs;
  logic [5:0]       edit_min;
  logic [5:0]       edit_sec;

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop synchronizer, then a rising-edge detector.
  // sample_valid marks when the edge flop holds a real post-reset sample, so a
  // button already held down when reset releases reads as "was high" and
  // produces no event until it is released and pressed again.
  // ---------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_sync    <= '0;
      inc_sync     <= '0;
      mode_prev    <= 1'b0;
      inc_prev     <= 1'b0;
      sample_valid <= '0;
    end else begin
      mode_sync    <= {mode_sync[0], BTN_MODE};
      inc_sync     <= {inc_sync[0], BTN_INC};
      mode_prev    <= mode_sync[1];
      inc_prev     <= inc_sync[1];
      sample_valid <= {sample_valid[1:0], 1'b1};
    end
  end

  assign mode_evt = sample_valid[2] & mode_sync[1] & ~mode_prev;
  assign inc_evt  = sample_valid[2] & inc_sync[1]  & ~inc_prev;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= RUN;
      load_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      load_q <= load_nxt;
    end
  end

  // MODE is checked before INC in every SET state, so a simultaneous INC is
  // simply dropped.
  // NOTE: each signal driven here gets a default first; a path that leaves one
  // unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    load_nxt  = 1'b0;
    capture   = 1'b0;
    inc_hrs   = 1'b0;
    inc_min   = 1'b0;
    inc_sec   = 1'b0;
    case (state)
      RUN: begin
        if (mode_evt) begin
          state_nxt = SET_HRS;
          capture   = 1'b1;
        end
      end
      SET_HRS: begin
        if (mode_evt)     state_nxt = SET_MIN;
        else if (inc_evt) inc_hrs   = 1'b1;
      end
      SET_MIN: begin
        if (mode_evt)     state_nxt = SET_SEC;
        else if (inc_evt) inc_min   = 1'b1;
      end
      SET_SEC: begin
        if (mode_evt) begin
          state_nxt = RUN;
          load_nxt  = 1'b1;
        end else if (inc_evt) begin
          inc_sec = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // 1 Hz prescaler. Held at 0 while setting and through the LOAD cycle, so
  // counting restarts on the cycle after LOAD and the first TICK lands exactly
  // TICK_DIV cycles after it. This also keeps TICK and LOAD mutually exclusive.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc <= '0;
    end else if (state != RUN || load_q || mode_evt) begin
      presc <= '0;
    end else if (presc == CNT_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  assign TICK = (state == RUN) && (presc == CNT_MAX);
  assign LOAD = load_q;

  // ---------------------------------------------------------------------------
  // Edit registers. Captured values are kept as-is even if out of range; the
  // ">=" limit compare makes the next INC of such a field wrap it to 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      edit_hrs <= '0;
      edit_min <= '0;
      edit_sec <= '0;
    end else if (capture) begin
      edit_hrs <= CUR_HRS;
      edit_min <= CUR_MIN;
      edit_sec <= CUR_SEC;
    end else begin
      if (inc_hrs) edit_hrs <= (edit_hrs >= 5'd23) ? 5'd0 : edit_hrs + 5'd1;
      if (inc_min) edit_min <= (edit_min >= 6'd59) ? 6'd0 : edit_min + 6'd1;
      if (inc_sec) edit_sec <= (edit_sec >= 6'd59) ? 6'd0 : edit_sec + 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign LOAD_HRS   = edit_hrs;
  assign LOAD_MIN   = edit_min;
  assign LOAD_SEC   = edit_sec;

  assign DISP_HRS   = (state == RUN) ? CUR_HRS : edit_hrs;
  assign DISP_MIN   = (state == RUN) ? CUR_MIN : edit_min;
  assign DISP_SEC   = (state == RUN) ? CUR_SEC : edit_sec;

  assign EDIT_FIELD = state;

endmodule

// File: tb/tb_watch_set_controller.sv
// -----------------------------------------------------------------------------
// tb_watch_set_controller
//
// Randomized bench for watch_set_controller with TICK_DIV = 4. The stimulus
// process keeps an abstract model (current field, edit values, start cycle of
// the current run interval) and pushes every TICK / LOAD it expects, stamped
// with its cycle number, into a queue. A monitor on the falling edge pops and
// compares whenever the DUT raises TICK or LOAD, and flags expected events
// that never show up.
// -----------------------------------------------------------------------------
module tb_watch_set_controller;

  localparam int TD  = 4;  // TICK_DIV under test
  localparam int GAP = 3;  // low cycles after each button press

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       BTN_MODE;
  logic       BTN_INC;
  logic [5:0] CUR_SEC;
  logic [5:0] CUR_MIN;
  logic [4:0] CUR_HRS;
  logic       TICK;
  logic       LOAD;
  logic [5:0] LOAD_SEC;
  logic [5:0] LOAD_MIN;
  logic [4:0] LOAD_HRS;
  logic [5:0] DISP_SEC;
  logic [5:0] DISP_MIN;
  logic [4:0] DISP_HRS;
  logic [1:0] EDIT_FIELD;

  always #5 CLK = ~CLK;

  watch_set_controller #(.TICK_DIV(TD)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN_MODE   (BTN_MODE),
    .BTN_INC    (BTN_INC),
    .CUR_SEC    (CUR_SEC),
    .CUR_MIN    (CUR_MIN),
    .CUR_HRS    (CUR_HRS),
    .TICK       (TICK),
    .LOAD       (LOAD),
    .LOAD_SEC   (LOAD_SEC),
    .LOAD_MIN   (LOAD_MIN),
    .LOAD_HRS   (LOAD_HRS),
    .DISP_SEC   (DISP_SEC),
    .DISP_MIN   (DISP_MIN),
    .DISP_HRS   (DISP_HRS),
    .EDIT_FIELD (EDIT_FIELD)
  );

  typedef struct {
    bit is_load;
    int cyc;
    int h;
    int m;
    int s;
  } exp_t;

  exp_t exp_q[$];

  int n_vec   = 0;
  int n_bad   = 0;
  int n_ticks = 0;
  int cur     = 0;   // cycles since the last reset release

  // Abstract model
  int tick_planned = -1;
  int run_start    = 0;
  bit run_active   = 1'b0;
  int field        = 0;  // 0 run, 1 hrs, 2 min, 3 sec
  int eh = 0, em = 0, es = 0;
  int ch = 0, cm = 0, cs = 0;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cur);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N === 1'b1) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cur) begin
        e = exp_q.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL missed_event: %s expected at cycle %0d, still pending at cycle %0d",
                 e.is_load ? "LOAD" : "TICK", e.cyc, cur);
      end
      if (TICK === 1'b1 || LOAD === 1'b1) begin
        if (TICK === 1'b1) n_ticks++;
        n_vec++;
        if (TICK === 1'b1 && LOAD === 1'b1) begin
          n_bad++;
          $display("FAIL tick_load_overlap: TICK=1 and LOAD=1 at cycle %0d, want at most one", cur);
        end
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: TICK=%0b LOAD=%0b at cycle %0d, want none",
                   TICK, LOAD, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cur || (e.is_load ? LOAD !== 1'b1 : TICK !== 1'b1) ||
              (e.is_load && (int'(LOAD_HRS) != e.h || int'(LOAD_MIN) != e.m ||
                             int'(LOAD_SEC) != e.s))) begin
            n_bad++;
            $display("FAIL event: got TICK=%0b LOAD=%0b %0d:%0d:%0d at cycle %0d, want %s %0d:%0d:%0d at cycle %0d",
                     TICK, LOAD, LOAD_HRS, LOAD_MIN, LOAD_SEC, cur,
                     e.is_load ? "LOAD" : "TICK", e.h, e.m, e.s, e.cyc);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge CLK);
    #1;
    cur++;
  endtask

  // Queue every tick of the current run interval up to and including 'upto'.
  task automatic plan_ticks(input int upto);
    exp_t x;
    for (int c = tick_planned + 1; c <= upto; c++) begin
      if (run_active && c >= run_start && (c - run_start) % TD == TD - 1) begin
        x.is_load = 1'b0;
        x.cyc     = c;
        x.h       = 0;
        x.m       = 0;
        x.s       = 0;
        exp_q.push_back(x);
      end
    end
    if (upto > tick_planned) tick_planned = upto;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    ch = h; cm = m; cs = s;
    CUR_HRS = 5'(h);
    CUR_MIN = 6'(m);
    CUR_SEC = 6'(s);
  endtask

  task automatic press(input bit m, input bit i, input int hold);
    BTN_MODE = m;
    BTN_INC  = i;
    repeat (hold) step();
    BTN_MODE = 1'b0;
    BTN_INC  = 1'b0;
    repeat (GAP) step();
  endtask

  task automatic idle(input int n);
    plan_ticks(cur + n - 1);
    repeat (n) step();
  endtask

  task automatic check_view(input string tag);
    check({tag, " edit_field"}, int'(EDIT_FIELD), field);
    check({tag, " disp_hrs"},   int'(DISP_HRS),   (field == 0) ? ch : eh);
    check({tag, " disp_min"},   int'(DISP_MIN),   (field == 0) ? cm : em);
    check({tag, " disp_sec"},   int'(DISP_SEC),   (field == 0) ? cs : es);
    check({tag, " load_hrs"},   int'(LOAD_HRS),   eh);
    check({tag, " load_min"},   int'(LOAD_MIN),   em);
    check({tag, " load_sec"},   int'(LOAD_SEC),   es);
  endtask

  // MODE press from RUN. A button raised in cycle e acts at the edge that
  // starts cycle e+3; cycle e+2 is still RUN and may carry a tick.
  task automatic mode_from_run(input bit timed);
    plan_ticks(cur + 2);
    run_active = 1'b0;
    BTN_MODE = 1'b1;
    step();
    step();
    if (timed) check("mode before k+2 edit_field", int'(EDIT_FIELD), 0);
    step();
    field = 1;
    eh = ch; em = cm; es = cs;
    if (timed) begin
      check_view("mode at k+2");
      check("tick in set_hrs", int'(TICK), 0);
    end
    BTN_MODE = 1'b0;
    repeat (GAP) step();
  endtask

  // MODE press from a SET state; with_inc also raises INC in the same cycle.
  task automatic mode_adv(input bit with_inc);
    exp_t x;
    if (field == 3) begin
      x.is_load = 1'b1;
      x.cyc     = cur + 3;
      x.h       = eh;
      x.m       = em;
      x.s       = es;
      exp_q.push_back(x);
      run_active   = 1'b1;
      run_start    = cur + 4;
      tick_planned = cur + 3;
      field        = 0;
      plan_ticks(cur + GAP);
    end else begin
      field++;
    end
    press(1'b1, with_inc, 1);
  endtask

  task automatic inc_press(input int hold);
    case (field)
      0: plan_ticks(cur + hold + GAP - 1);
      1: eh = (eh >= 23) ? 0 : eh + 1;
      2: em = (em >= 59) ? 0 : em + 1;
      default: es = (es >= 59) ? 0 : es + 1;
    endcase
    press(1'b0, 1'b1, hold);
  endtask

  task automatic release_reset();
    RST_N        = 1'b1;
    cur          = 0;
    run_active   = 1'b1;
    run_start    = 0;
    tick_planned = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    RST_N    = 1'b0;
    BTN_MODE = 1'b0;
    BTN_INC  = 1'b0;
    set_cur(7, 8, 9);
    repeat (3) @(posedge CLK);
    #1;
    check_view("in reset");
    check("tick in reset", int'(TICK), 0);
    check("load in reset", int'(LOAD), 0);

    // Free run: ticks at cycles 3, 7, 11, 15, 19.
    release_reset();
    idle(20);
    check("ticks in first 20 cycles", n_ticks, 5);

    for (int it = 0; it < 6; it++) begin
      if (it == 0)      set_cur(12, 34, 56);
      else if (it == 1) set_cur(0, 59, 56);
      else              set_cur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      idle($urandom_range(2, 9));
      check_view("run");
      if (it % 2 == 1) begin
        inc_press(1);
        check_view("inc ignored in run");
      end

      mode_from_run(it == 0);
      check_view("set_hrs");

      if (it == 0)      n = 12;
      else if (it == 1) n = 0;
      else              n = $urandom_range(0, 26);
      for (int k = 0; k < n; k++) inc_press(1);
      check_view("after hrs incs");

      mode_adv(it == 2 || it == 4);
      check_view("set_min");
      if (it == 1)      n = 1;
      else if (it == 5) n = 60;
      else              n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) inc_press(1);
      check_view("after min incs");

      mode_adv(1'b0);
      check_view("set_sec");
      if (it == 3) begin
        inc_press(100);
        check_view("long inc hold");
      end else begin
        n = (it == 1) ? 0 : $urandom_range(0, 8);
        for (int k = 0; k < n; k++) inc_press(1);
        check_view("after sec incs");
      end

      mode_adv(1'b0);
      check_view("back to run");
      idle(TD + 4);
    end

    // Reset in the middle of an edit: no LOAD, edit abandoned.
    set_cur(3, 4, 5);
    mode_from_run(1'b0);
    mode_adv(1'b0);
    mode_adv(1'b0);
    inc_press(1);
    check_view("before reset in set_sec");
    check("queue drained before reset", exp_q.size(), 0);
    exp_q.delete();
    RST_N = 1'b0;
    #1;
    field = 0;
    eh = 0; em = 0; es = 0;
    check_view("reset during set_sec");
    check("tick during reset", int'(TICK), 0);
    check("load during reset", int'(LOAD), 0);

    // MODE held through reset release must not count as a press.
    BTN_MODE = 1'b1;
    repeat (3) step();
    release_reset();
    idle(12);
    check_view("mode held through reset");
    BTN_MODE = 1'b0;
    idle(4);

    // A fresh press works again.
    mode_from_run(1'b1);
    inc_press(1);
    mode_adv(1'b0);
    mode_adv(1'b0);
    mode_adv(1'b0);
    check_view("final load");
    idle(2 * TD + 2);
    check("events outstanding at end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cur);
    $fatal(1);
  end

endmodule
